// File: rtl/scan_mem_bridge_if.sv
// Memory-side request/grant bus between scan_mem_bridge and the SRAM/register fabric.
// The bridge is the master; the fabric (or a bench model) is the slave.
interface scan_mem_bridge_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 32
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );

endinterface

// File: rtl/scan_mem_bridge.sv
// Tester scan-chain responder: a master/slave shift chain with shadow registers, where each
// scan_id toggle becomes one memory read or write and results return through the chain.
module scan_mem_bridge #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_phi,
   input  logic              scan_phi_bar,
   input  logic              scan_data_in,
   input  logic              scan_load_chip,
   input  logic              scan_load_chain,
   input  logic              scan_id,
   output logic              scan_data_out,
   output logic              busy,
   scan_mem_bridge_if.master mem
);

   localparam int unsigned ChainLen = 2 + ADDR_W + 2 * DATA_W + 1;
   localparam int unsigned NumSync  = 6;
   localparam int unsigned AddrLsb  = 2;
   localparam int unsigned WdataLsb = 2 + ADDR_W;

   typedef enum logic [1:0] {StIdle, StReq, StRwait, StDone} state_e;

   // ---------------------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][NumSync-1:0] sync_q;
   logic [NumSync-1:0]                  sync_raw;
   logic [NumSync-1:0]                  sync_s;
   logic                                phi_s, phi_bar_s, data_in_s;
   logic                                load_chip_s, load_chain_s, id_s;
   logic [2:0]                          prev_q;
   logic                                phi_rise, phi_bar_rise, load_chip_rise;

   assign sync_raw = {scan_id, scan_load_chain, scan_load_chip, scan_data_in, scan_phi_bar,
                      scan_phi};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sync_raw};
         prev_q <= {load_chip_s, phi_bar_s, phi_s};
      end
   end

   assign sync_s       = sync_q[SYNC_STAGES-1];
   assign phi_s        = sync_s[0];
   assign phi_bar_s    = sync_s[1];
   assign data_in_s    = sync_s[2];
   assign load_chip_s  = sync_s[3];
   assign load_chain_s = sync_s[4];
   assign id_s         = sync_s[5];

   assign phi_rise       = phi_s & ~prev_q[0];
   assign phi_bar_rise   = phi_bar_s & ~prev_q[1];
   assign load_chip_rise = load_chip_s & ~prev_q[2];

   // ---------------------------------------------------------------------------------------
   // Scan chain and shadow registers
   // ---------------------------------------------------------------------------------------
   logic [ChainLen-1:0] master_q, slave_q, capture;
   logic                sh_wen_q, sh_ren_q;
   logic [ADDR_W-1:0]   sh_addr_q;
   logic [DATA_W-1:0]   sh_wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ready_q;

   assign capture = {ready_q, rdata_q, sh_wdata_q, sh_addr_q, sh_ren_q, sh_wen_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         master_q      <= '0;
         slave_q       <= '0;
         scan_data_out <= 1'b0;
      end else begin
         if (phi_rise) begin
            master_q <= load_chain_s ? capture : {data_in_s, slave_q[ChainLen-1:1]};
         end
         if (phi_bar_rise) begin
            slave_q <= master_q;
         end
         scan_data_out <= slave_q[0];
      end
   end

   // rdata/ready chain fields are status only; an update never writes them back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_wen_q   <= 1'b0;
         sh_ren_q   <= 1'b0;
         sh_addr_q  <= '0;
         sh_wdata_q <= '0;
      end else if (load_chip_rise) begin
         sh_wen_q   <= slave_q[0];
         sh_ren_q   <= slave_q[1];
         sh_addr_q  <= slave_q[AddrLsb +: ADDR_W];
         sh_wdata_q <= slave_q[WdataLsb +: DATA_W];
      end
   end

   // ---------------------------------------------------------------------------------------
   // Request FSM
   // ---------------------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic              id_last_q;
   logic              pending;
   logic              accept;
   logic              rd_done;
   logic              op_we_q;
   logic [ADDR_W-1:0] op_addr_q;
   logic [DATA_W-1:0] op_wdata_q;

   assign pending = (id_s != id_last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      rd_done = 1'b0;
      case (state_q)
         StIdle: begin
            if (pending) begin
               accept  = 1'b1;
               state_d = (sh_wen_q || sh_ren_q) ? StReq : StDone;
            end
         end
         StReq: begin
            if (mem.mem_gnt) begin
               state_d = op_we_q ? StDone : StRwait;
            end
         end
         StRwait: begin
            if (mem.mem_rvalid) begin
               rd_done = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Operands are frozen at accept so shadow/chain activity cannot disturb an in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_last_q  <= 1'b0;
         op_we_q    <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
      end else begin
         if (accept) begin
            id_last_q  <= id_s;
            op_we_q    <= sh_wen_q;
            op_addr_q  <= sh_addr_q;
            op_wdata_q <= sh_wdata_q;
            ready_q    <= 1'b0;
         end
         if (rd_done) begin
            rdata_q <= mem.mem_rdata;
         end
         if (state_q == StDone) begin
            ready_q <= 1'b1;
         end
      end
   end

   assign mem.mem_req   = (state_q == StReq);
   assign mem.mem_we    = op_we_q;
   assign mem.mem_addr  = op_addr_q;
   assign mem.mem_wdata = op_wdata_q;
   assign busy          = (state_q != StIdle);

endmodule
